// File: rtl/single_port_ram_controller_if.sv
// Bus bundle for single_port_ram_controller: write-request, read-request and
// read-response channels plus the port toward the single_port_ram instance.
// The slave modport is the controller's view; master is the client/RAM side.
interface single_port_ram_controller_if #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4
);
  // Write request channel
  logic                     write_request_valid;
  logic                     write_request_ready;
  logic [ADDRESS_WIDTH-1:0] write_request_address;
  logic [WIDTH-1:0]         write_request_data;
  // Read request channel
  logic                     read_request_valid;
  logic                     read_request_ready;
  logic [ADDRESS_WIDTH-1:0] read_request_address;
  // Read response channel
  logic                     read_response_valid;
  logic                     read_response_ready;
  logic [WIDTH-1:0]         read_response_data;
  // RAM port
  logic                     memory_write_enable;
  logic                     memory_read_enable;
  logic [ADDRESS_WIDTH-1:0] memory_address;
  logic [WIDTH-1:0]         memory_write_data;
  logic [WIDTH-1:0]         memory_read_data;

  modport slave (
    input  write_request_valid, write_request_address, write_request_data,
    output write_request_ready,
    input  read_request_valid, read_request_address,
    output read_request_ready,
    output read_response_valid, read_response_data,
    input  read_response_ready,
    output memory_write_enable, memory_read_enable, memory_address, memory_write_data,
    input  memory_read_data
  );

  modport master (
    output write_request_valid, write_request_address, write_request_data,
    input  write_request_ready,
    output read_request_valid, read_request_address,
    input  read_request_ready,
    input  read_response_valid, read_response_data,
    output read_response_ready,
    input  memory_write_enable, memory_read_enable, memory_address, memory_write_data,
    output memory_read_data
  );
endinterface

// File: rtl/single_port_ram_controller.sv
// single_port_ram_controller: arbitrates independent write and read request
// channels onto one RAM port and registers read data into a response channel.
// Optional feature macro: SINGLE_PORT_RAM_CONTROLLER_ROUND_ROBIN_EN
//   defined   -> contended cycles alternate write/read (write wins first)
//   undefined -> fixed write priority
module single_port_ram_controller #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                        clock,
  input  logic                        resetn,
  single_port_ram_controller_if.slave bus
);

  logic                 r_read_response_valid;
  logic [WIDTH-1:0]     r_read_response_data;

  logic                 w_write_request;
  logic                 w_read_eligible;
  logic                 w_grant_write;
  logic                 w_grant_read;
  logic                 w_response_taken;

  // A read may only be granted when the response register is free or being
  // drained this cycle, so an unconsumed response is never overwritten.
  assign w_write_request  = bus.write_request_valid;
  assign w_read_eligible  = bus.read_request_valid &&
                            (!r_read_response_valid || bus.read_response_ready);
  assign w_response_taken = r_read_response_valid && bus.read_response_ready;

`ifdef SINGLE_PORT_RAM_CONTROLLER_ROUND_ROBIN_EN
  logic r_last_grant_was_read;

  // On contention grant the opposite of the previous contended winner.
  assign w_grant_write = w_write_request && (!w_read_eligible || r_last_grant_was_read);
  assign w_grant_read  = w_read_eligible && (!w_write_request || !r_last_grant_was_read);

  // Track the winner of contended cycles only; reset to 1 so write wins first.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_last_grant_was_read <= 1'b1;
    end else if (w_write_request && w_read_eligible) begin
      r_last_grant_was_read <= w_grant_read;
    end
  end
`else
  // Fixed priority: any valid write wins, reads fill the remaining cycles.
  assign w_grant_write = w_write_request;
  assign w_grant_read  = w_read_eligible && !w_write_request;
`endif

  // Handshake readies and RAM port; address/data are forced to 0 when idle.
  assign bus.write_request_ready = w_grant_write;
  assign bus.read_request_ready  = w_grant_read;
  assign bus.memory_write_enable = w_grant_write;
  assign bus.memory_read_enable  = w_grant_read;
  assign bus.memory_address      = w_grant_write ? bus.write_request_address :
                                   w_grant_read  ? bus.read_request_address  :
                                                   '0;
  assign bus.memory_write_data   = w_grant_write ? bus.write_request_data : '0;

  assign bus.read_response_valid = r_read_response_valid;
  assign bus.read_response_data  = r_read_response_data;

  // Response register: load on read grant, clear on consumption, else hold.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_read_response_valid <= 1'b0;
      r_read_response_data  <= '0;
    end else if (w_grant_read) begin
      r_read_response_valid <= 1'b1;
      r_read_response_data  <= bus.memory_read_data;
    end else if (w_response_taken) begin
      r_read_response_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_single_port_ram_controller.sv
// Testbench for single_port_ram_controller: table of per-cycle stimulus and
// expected combinational outputs, a behavioural RAM, a shadow memory and a
// scoreboard queue of expected read responses.
module tb_single_port_ram_controller;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clock;
  logic resetn;

  single_port_ram_controller_if #(.WIDTH(WIDTH), .ADDRESS_WIDTH(AW)) bus();

  single_port_ram_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // Behavioural RAM: combinational read, write at the clock edge.
  logic [WIDTH-1:0] ram [DEPTH];
  assign bus.memory_read_data = ram[bus.memory_address];
  always @(posedge clock) begin
    if (bus.memory_write_enable) ram[bus.memory_address] <= bus.memory_write_data;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic             wv;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             rv;
    logic [AW-1:0]    ra;
    logic             rr;
    logic             e_wrdy;
    logic             e_rrdy;
    logic             e_mwe;
    logic             e_mre;
    logic [AW-1:0]    e_maddr;
    logic [WIDTH-1:0] e_mwd;
    logic             e_rvalid;
    logic             chk_rdata;
    logic [WIDTH-1:0] e_rdata;
  } vec_t;

  vec_t             vecs[$];
  logic [WIDTH-1:0] shadow [DEPTH];
  logic [WIDTH-1:0] sb[$];
  int               n_checks;
  int               n_errors;

  function automatic vec_t mk(
    input logic wv, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
    input logic rv, input logic [AW-1:0] ra, input logic rr,
    input logic e_wrdy, input logic e_rrdy, input logic e_mwe, input logic e_mre,
    input logic [AW-1:0] e_maddr, input logic [WIDTH-1:0] e_mwd,
    input logic e_rvalid, input logic chk_rdata, input logic [WIDTH-1:0] e_rdata);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rr = rr;
    v.e_wrdy = e_wrdy; v.e_rrdy = e_rrdy; v.e_mwe = e_mwe; v.e_mre = e_mre;
    v.e_maddr = e_maddr; v.e_mwd = e_mwd; v.e_rvalid = e_rvalid;
    v.chk_rdata = chk_rdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle after the falling edge, compare 1 time unit later.
  task automatic apply(input vec_t v, input string tag);
    logic [WIDTH-1:0] exp_data;
    @(negedge clock);
    bus.write_request_valid   = v.wv;
    bus.write_request_address = v.wa;
    bus.write_request_data    = v.wd;
    bus.read_request_valid    = v.rv;
    bus.read_request_address  = v.ra;
    bus.read_response_ready   = v.rr;
    #1;
    check({tag, "_wrdy"},   32'(bus.write_request_ready), 32'(v.e_wrdy));
    check({tag, "_rrdy"},   32'(bus.read_request_ready),  32'(v.e_rrdy));
    check({tag, "_mwe"},    32'(bus.memory_write_enable), 32'(v.e_mwe));
    check({tag, "_mre"},    32'(bus.memory_read_enable),  32'(v.e_mre));
    check({tag, "_maddr"},  32'(bus.memory_address),      32'(v.e_maddr));
    check({tag, "_mwd"},    32'(bus.memory_write_data),   32'(v.e_mwd));
    check({tag, "_rvalid"}, 32'(bus.read_response_valid), 32'(v.e_rvalid));
    if (v.chk_rdata) check({tag, "_rdata"}, 32'(bus.read_response_data), 32'(v.e_rdata));
    // Scoreboard: pop on response handshake, push on read grant.
    if (bus.read_response_valid && v.rr) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s_sb: got response %0h, expected none", tag, bus.read_response_data);
      end else begin
        exp_data = sb.pop_front();
        check({tag, "_sb"}, 32'(bus.read_response_data), 32'(exp_data));
      end
    end
    if (v.rv && bus.read_request_ready) sb.push_back(shadow[v.ra]);
    if (v.wv && bus.write_request_ready) shadow[v.wa] = v.wd;
    $display("%s: wv=%0d wa=%0h wd=%0h rv=%0d ra=%0h rr=%0d | wrdy=%0d rrdy=%0d maddr=%0h rvalid=%0d rdata=%0h",
             tag, v.wv, v.wa, v.wd, v.rv, v.ra, v.rr, bus.write_request_ready,
             bus.read_request_ready, bus.memory_address, bus.read_response_valid,
             bus.read_response_data);
  endtask

  function automatic vec_t idle(input logic rr);
    return mk(0, 0, 0, 0, 0, rr, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    vec_t v;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    resetn = 1'b0;
    bus.write_request_valid   = 0;
    bus.write_request_address = 0;
    bus.write_request_data    = 0;
    bus.read_request_valid    = 0;
    bus.read_request_address  = 0;
    bus.read_response_ready   = 0;

    // ---- reset state ----
    #1;
    check("rst_rvalid", 32'(bus.read_response_valid), 0);
    check("rst_rdata",  32'(bus.read_response_data), 0);
    check("rst_mwe",    32'(bus.memory_write_enable), 0);
    check("rst_mre",    32'(bus.memory_read_enable), 0);
    check("rst_maddr",  32'(bus.memory_address), 0);
    check("rst_mwd",    32'(bus.memory_write_data), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    // ---- table ----
    // write A5 @3, read it back next cycle, response the cycle after
    vecs.push_back(mk(1, 3, 8'hA5, 0, 0, 1, 1, 0, 1, 0, 3, 8'hA5, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     1, 3, 1, 0, 1, 0, 1, 3, 0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0,     1, 1, 8'hA5));
    // pre-writes 0x10..0x13 @0..3 and 0x3C @5
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, AW'(i), 8'(8'h10 + i), 0, 0, 1, 1, 0, 1, 0, AW'(i), 8'(8'h10 + i), 0, 0, 0));
    vecs.push_back(mk(1, 5, 8'h3C, 0, 0, 1, 1, 0, 1, 0, 5, 8'h3C, 0, 0, 0));
    // back-to-back reads of 0..3, one response per cycle with latency 1
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 1; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 1, AW'(i), 1, 0, 1, 0, 1, AW'(i), 0, 1, 1, 8'(8'h10 + i - 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 8'h13));
    // sustained contention for 4 cycles
`ifdef SINGLE_PORT_RAM_CONTROLLER_ROUND_ROBIN_EN
    vecs.push_back(mk(1, 8,  8'h80, 1, 0, 1, 1, 0, 1, 0, 8,  8'h80, 0, 0, 0));
    vecs.push_back(mk(1, 9,  8'h81, 1, 0, 1, 0, 1, 0, 1, 0,  0,     0, 0, 0));
    vecs.push_back(mk(1, 10, 8'h82, 1, 0, 1, 1, 0, 1, 0, 10, 8'h82, 1, 1, 8'h10));
    vecs.push_back(mk(1, 11, 8'h83, 1, 0, 1, 0, 1, 0, 1, 0,  0,     0, 0, 0));
    vecs.push_back(mk(0, 0,  0,     0, 0, 1, 0, 0, 0, 0, 0,  0,     1, 1, 8'h10));
`else
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, AW'(8 + i), 8'(8'h80 + i), 1, 0, 1, 1, 0, 1, 0, AW'(8 + i), 8'(8'h80 + i), 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
    // response stall: read 5, consumer not ready; second read waits, write to 7 proceeds
    vecs.push_back(mk(0, 0, 0,     1, 5, 0, 0, 1, 0, 1, 5, 0,     0, 0, 0));
    vecs.push_back(mk(1, 7, 8'h77, 1, 6, 0, 1, 0, 1, 0, 7, 8'h77, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 0, 0,     1, 6, 0, 0, 0, 0, 0, 0, 0,     1, 1, 8'h3C));
    vecs.push_back(mk(0, 0, 0,     1, 6, 0, 0, 0, 0, 0, 0, 0,     1, 1, 8'h3C));
    vecs.push_back(mk(0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0,     1, 1, 8'h3C));
    vecs.push_back(mk(0, 0, 0,     1, 7, 1, 0, 1, 0, 1, 7, 0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0,     1, 1, 8'h77));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

    // ---- reset while a response is pending ----
    // contended cycle: write wins (round-robin state now says read is next)
    apply(mk(1, 4, 8'h44, 1, 0, 1, 1, 0, 1, 0, 4, 8'h44, 0, 0, 0), "rs0");
    apply(mk(0, 0, 0,     1, 3, 0, 0, 1, 0, 1, 3, 0,     0, 0, 0), "rs1");
    apply(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 1, 8'h13), "rs2");
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("rs_async_rvalid", 32'(bus.read_response_valid), 0);
    check("rs_async_rdata",  32'(bus.read_response_data), 0);
    sb.delete();
    $display("rs: resetn asserted, rvalid=%0d rdata=%0h", bus.read_response_valid, bus.read_response_data);
    @(negedge clock);
    resetn = 1'b1;
    // first contended grant after reset must be the write
    apply(mk(1, 6, 8'h66, 1, 0, 1, 1, 0, 1, 0, 6, 8'h66, 0, 0, 0), "rs3");
    apply(idle(1), "rs4");

    // ---- idle for 10 cycles ----
    for (int i = 0; i < 10; i++) apply(idle(0), $sformatf("idle%0d", i));

    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
